// File: rtl/cam_fill_ctrl.sv
// cam_fill_ctrl: lookup/fill controller sitting in front of one CAM instance.
// Takes client tag requests and looks each tag up in the CAM. A miss is
// fetched from backing memory over a req/ack handshake and then written into
// a free entry, or into a round-robin victim once every entry is allocated.
// The response goes back to the client with a hit/miss flag.
// Optional build feature: define CAM_FILL_STATS_EN to add saturating
// hit/miss/eviction counters and a synchronous stats_clr input.
module cam_fill_ctrl #(
  parameter int WORDS     = 8,
  parameter int BITS      = 8,
  parameter int TAG_SZ    = 8,
  parameter int ADDR_LEFT = $clog2(WORDS) - 1
`ifdef CAM_FILL_STATS_EN
  ,
  parameter int CNT_W     = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst_,
  input  logic                 req_valid,
  input  logic [TAG_SZ-1:0]    req_tag,
  output logic                 req_ready,
  output logic                 resp_valid,
  output logic [BITS-1:0]      resp_data,
  output logic                 resp_hit,
  input  logic                 resp_ready,
  output logic [TAG_SZ-1:0]    cam_check_tag,
  input  logic                 cam_found_it,
  input  logic [BITS-1:0]      cam_data,
  output logic                 cam_write_,
  output logic [ADDR_LEFT:0]   cam_w_addr,
  output logic [TAG_SZ-1:0]    cam_new_tag,
  output logic [BITS-1:0]      cam_wdata,
  output logic                 cam_new_valid,
  output logic                 full,
  output logic                 mem_req,
  output logic [TAG_SZ-1:0]    mem_tag,
  input  logic                 mem_ack,
  input  logic [BITS-1:0]      mem_rdata
`ifdef CAM_FILL_STATS_EN
  ,
  input  logic                 stats_clr,
  output logic [CNT_W-1:0]     hit_cnt,
  output logic [CNT_W-1:0]     miss_cnt,
  output logic [CNT_W-1:0]     evict_cnt
`endif
);

  localparam int AW = ADDR_LEFT + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    MREQ   = 3'd2,
    FILL   = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [TAG_SZ-1:0] r_tagQ;
  logic [BITS-1:0]   r_dataQ;
  logic              r_respHit;
  logic [WORDS-1:0]  r_alloc;
  logic [WORDS-1:0]  w_allocNext;
  logic [AW-1:0]     r_rrPtr;
  logic [AW-1:0]     r_victim;
  logic [AW-1:0]     w_victimSel;
  logic              r_evict;
  logic              r_full;
  logic              w_allocFull;

  assign w_allocFull   = &r_alloc;
  assign cam_check_tag = r_tagQ;
  assign full          = r_full;
  assign resp_hit      = r_respHit;

  // State register; reset aborts any transaction in flight, dropping mem_req and any pending write at once
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode plus the handshake and CAM write-port outputs, all decoded from the current state
  always_comb begin
    w_nextState   = r_state;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_data     = '0;
    cam_write_    = 1'b1;
    cam_w_addr    = '0;
    cam_new_tag   = '0;
    cam_wdata     = '0;
    cam_new_valid = 1'b0;
    mem_req       = 1'b0;
    mem_tag       = '0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_nextState = LOOKUP;
        end
      end
      LOOKUP: begin
        if (cam_found_it) begin
          w_nextState = RESP;
        end else begin
          w_nextState = MREQ;
        end
      end
      MREQ: begin
        mem_req = 1'b1;
        mem_tag = r_tagQ;
        if (mem_ack) begin
          w_nextState = FILL;
        end
      end
      FILL: begin
        cam_write_    = 1'b0;
        cam_w_addr    = r_victim;
        cam_new_tag   = r_tagQ;
        cam_wdata     = r_dataQ;
        cam_new_valid = 1'b1;
        w_nextState   = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_data  = r_dataQ;
        if (resp_ready) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Victim choice: lowest unallocated entry, falling back to the round-robin pointer when all are taken
  always_comb begin
    w_victimSel = r_rrPtr;
    for (int i = WORDS - 1; i >= 0; i--) begin
      if (!r_alloc[i]) begin
        w_victimSel = AW'(i);
      end
    end
  end

  // Allocation bitmap as it will look after this cycle; only a fill can set a bit
  always_comb begin
    w_allocNext = r_alloc;
    if (r_state == FILL) begin
      w_allocNext[r_victim] = 1'b1;
    end
  end

  // Transaction datapath: captured tag, response data, hit flag and the victim chosen when memory answers
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_tagQ    <= '0;
      r_dataQ   <= '0;
      r_respHit <= 1'b0;
      r_victim  <= '0;
      r_evict   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_tagQ <= req_tag;
          end
        end
        LOOKUP: begin
          if (cam_found_it) begin
            r_dataQ   <= cam_data;
            r_respHit <= 1'b1;
          end
        end
        MREQ: begin
          if (mem_ack) begin
            r_dataQ  <= mem_rdata;
            r_victim <= w_victimSel;
            r_evict  <= w_allocFull;
          end
        end
        FILL: begin
          r_respHit <= 1'b0;
        end
        default: begin
          r_tagQ <= r_tagQ;
        end
      endcase
    end
  end

  // Allocation tracking, full flag and round-robin pointer; the pointer wraps explicitly so any WORDS works
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_alloc <= '0;
      r_full  <= 1'b0;
      r_rrPtr <= '0;
    end else begin
      r_alloc <= w_allocNext;
      r_full  <= &w_allocNext;
      if ((r_state == FILL) && r_evict) begin
        if (r_rrPtr == AW'(WORDS - 1)) begin
          r_rrPtr <= '0;
        end else begin
          r_rrPtr <= r_rrPtr + 1'b1;
        end
      end
    end
  end

`ifdef CAM_FILL_STATS_EN
  logic [CNT_W-1:0] r_hitCnt;
  logic [CNT_W-1:0] r_missCnt;
  logic [CNT_W-1:0] r_evictCnt;

  assign hit_cnt   = r_hitCnt;
  assign miss_cnt  = r_missCnt;
  assign evict_cnt = r_evictCnt;

  // Saturating event counters; a clear in the same cycle as an event takes priority
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_hitCnt   <= '0;
      r_missCnt  <= '0;
      r_evictCnt <= '0;
    end else if (stats_clr) begin
      r_hitCnt   <= '0;
      r_missCnt  <= '0;
      r_evictCnt <= '0;
    end else begin
      if ((r_state == LOOKUP) && cam_found_it && (r_hitCnt != '1)) begin
        r_hitCnt <= r_hitCnt + 1'b1;
      end
      if ((r_state == LOOKUP) && !cam_found_it && (r_missCnt != '1)) begin
        r_missCnt <= r_missCnt + 1'b1;
      end
      if ((r_state == FILL) && r_evict && (r_evictCnt != '1)) begin
        r_evictCnt <= r_evictCnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cam_fill_ctrl.sv
// tb_cam_fill_ctrl: directed bench for cam_fill_ctrl with a small behavioural
// CAM and a hand-driven memory port. Expected values are written out per test.
module tb_cam_fill_ctrl;

  logic       clk = 1'b0;
  logic       rst_ = 1'b0;
  logic       req_valid = 1'b0;
  logic [7:0] req_tag = '0;
  logic       req_ready;
  logic       resp_valid;
  logic [7:0] resp_data;
  logic       resp_hit;
  logic       resp_ready = 1'b0;
  logic [7:0] cam_check_tag;
  logic       cam_found_it;
  logic [7:0] cam_data;
  logic       cam_write_;
  logic [2:0] cam_w_addr;
  logic [7:0] cam_new_tag;
  logic [7:0] cam_wdata;
  logic       cam_new_valid;
  logic       full;
  logic       mem_req;
  logic [7:0] mem_tag;
  logic       mem_ack = 1'b0;
  logic [7:0] mem_rdata = '0;
`ifdef CAM_FILL_STATS_EN
  logic        stats_clr = 1'b0;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
  logic [15:0] evict_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] camTag   [8];
  logic [7:0] camData  [8];
  logic [7:0] camValid;

  cam_fill_ctrl dut (
    .clk(clk), .rst_(rst_),
    .req_valid(req_valid), .req_tag(req_tag), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_hit(resp_hit),
    .resp_ready(resp_ready),
    .cam_check_tag(cam_check_tag), .cam_found_it(cam_found_it), .cam_data(cam_data),
    .cam_write_(cam_write_), .cam_w_addr(cam_w_addr), .cam_new_tag(cam_new_tag),
    .cam_wdata(cam_wdata), .cam_new_valid(cam_new_valid),
    .full(full), .mem_req(mem_req), .mem_tag(mem_tag),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef CAM_FILL_STATS_EN
    , .stats_clr(stats_clr), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .evict_cnt(evict_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural CAM storage, cleared together with the controller
  always @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      camValid <= '0;
    end else if (!cam_write_) begin
      camTag[cam_w_addr]   <= cam_new_tag;
      camData[cam_w_addr]  <= cam_wdata;
      camValid[cam_w_addr] <= cam_new_valid;
    end
  end

  // Combinational CAM match on the controller's lookup tag
  always_comb begin
    cam_found_it = 1'b0;
    cam_data     = '0;
    for (int i = 0; i < 8; i++) begin
      if (camValid[i] && (camTag[i] == cam_check_tag)) begin
        cam_found_it = 1'b1;
        cam_data     = camData[i];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_req_ready"}, req_ready, 1);
    checkOutput({tag, "_cam_write_"}, cam_write_, 1);
    checkOutput({tag, "_mem_req"}, mem_req, 0);
    checkOutput({tag, "_resp_valid"}, resp_valid, 0);
    checkOutput({tag, "_full"}, full, 0);
    checkOutput({tag, "_check_tag"}, cam_check_tag, 0);
  endtask

  // Asserts reset between clock edges and checks the outputs settle without any clock
  task automatic resetMidCycle(input string tag);
    #2 rst_ = 1'b0;
    #1 checkResetState(tag);
    @(negedge clk);
    rst_ = 1'b1;
  endtask

  // One full client transaction; on a miss the memory answers ackDelay cycles into MREQ
  task automatic applyStimulus(input logic [7:0] tag, input bit expHit, input logic [7:0] expData,
                               input int ackDelay, input int expAddr, input int readyDelay);
    @(negedge clk);
    checkOutput("idle_ready", req_ready, 1);
    req_valid = 1'b1;
    req_tag   = tag;
    @(negedge clk);
    req_valid = 1'b0;
    req_tag   = '0;
    checkOutput("lookup_tag", cam_check_tag, tag);
    checkOutput("lookup_ready", req_ready, 0);
    if (!expHit) begin
      @(negedge clk);
      checkOutput("mem_req", mem_req, 1);
      checkOutput("mem_tag", mem_tag, tag);
      req_valid = 1'b1;
      req_tag   = 8'hEE;
      repeat (ackDelay) begin
        @(negedge clk);
        checkOutput("busy_ready", req_ready, 0);
        checkOutput("mem_req_hold", mem_req, 1);
        checkOutput("mem_tag_hold", mem_tag, tag);
        checkOutput("no_early_write", cam_write_, 1);
      end
      mem_ack   = 1'b1;
      mem_rdata = expData;
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = '0;
      req_valid = 1'b0;
      req_tag   = '0;
      checkOutput("fill_write_", cam_write_, 0);
      checkOutput("fill_addr", cam_w_addr, expAddr);
      checkOutput("fill_tag", cam_new_tag, tag);
      checkOutput("fill_data", cam_wdata, expData);
      checkOutput("fill_valid", cam_new_valid, 1);
      checkOutput("fill_mem_req", mem_req, 0);
    end else begin
      checkOutput("hit_no_mem_req", mem_req, 0);
    end
    @(negedge clk);
    checkOutput("resp_valid", resp_valid, 1);
    checkOutput("resp_data", resp_data, expData);
    checkOutput("resp_hit", resp_hit, expHit);
    checkOutput("resp_write_", cam_write_, 1);
    checkOutput("resp_mem_req", mem_req, 0);
    repeat (readyDelay) begin
      @(negedge clk);
      checkOutput("resp_hold_valid", resp_valid, 1);
      checkOutput("resp_hold_data", resp_data, expData);
      checkOutput("resp_hold_hit", resp_hit, expHit);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    checkOutput("resp_done", resp_valid, 0);
    checkOutput("back_idle", req_ready, 1);
  endtask

  initial begin
    // Power-on reset: outputs must be at their idle values before any edge
    #1 checkResetState("por");
    @(negedge clk);
    rst_ = 1'b1;

    // Cold miss then hit on the same tag
    applyStimulus(8'h5A, 1'b0, 8'h33, 3, 0, 0);
    applyStimulus(8'h5A, 1'b1, 8'h33, 0, 0, 0);
`ifdef CAM_FILL_STATS_EN
    checkOutput("stat_hit", hit_cnt, 1);
    checkOutput("stat_miss", miss_cnt, 1);
    checkOutput("stat_evict", evict_cnt, 0);
    @(negedge clk);
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    checkOutput("clr_hit", hit_cnt, 0);
    checkOutput("clr_miss", miss_cnt, 0);
    checkOutput("clr_evict", evict_cnt, 0);
`endif

    // Idle mid-cycle reset, then fill all entries from empty
    @(negedge clk);
    resetMidCycle("idle_rst");
    for (int i = 0; i < 8; i++) begin
      checkOutput("not_full", full, 0);
      applyStimulus(8'(i + 1), 1'b0, 8'(i + 1) ^ 8'hA0, 1, i, 0);
    end
    checkOutput("full_set", full, 1);

    // Evictions: round-robin from entry 0, wrapping after entry 7
    for (int i = 0; i < 10; i++) begin
      applyStimulus(8'(i + 9), 1'b0, 8'(i + 9) ^ 8'hA0, 1, (i % 8), 0);
    end
    checkOutput("full_hold", full, 1);
`ifdef CAM_FILL_STATS_EN
    checkOutput("stat_evict10", evict_cnt, 10);
`endif
    applyStimulus(8'h12, 1'b1, 8'hB2, 0, 0, 0);
    applyStimulus(8'h09, 1'b0, 8'h9C, 1, 2, 0);

    // Backpressure on both the memory and the client side
    applyStimulus(8'h20, 1'b0, 8'hC4, 10, 3, 4);

    // Abort during MREQ, then a stray mem_ack must be ignored
    @(negedge clk);
    req_valid = 1'b1;
    req_tag   = 8'h40;
    @(negedge clk);
    req_valid = 1'b0;
    req_tag   = '0;
    @(negedge clk);
    checkOutput("abort_mem_req", mem_req, 1);
    resetMidCycle("abort_rst");
    mem_ack   = 1'b1;
    mem_rdata = 8'h77;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = '0;
    checkOutput("stray_write_", cam_write_, 1);
    checkOutput("stray_ready", req_ready, 1);
    checkOutput("stray_mem_req", mem_req, 0);
    @(negedge clk);
    checkOutput("stray_write_2", cam_write_, 1);
`ifdef CAM_FILL_STATS_EN
    checkOutput("rst_hit", hit_cnt, 0);
    checkOutput("rst_miss", miss_cnt, 0);
    checkOutput("rst_evict", evict_cnt, 0);
`endif
    applyStimulus(8'h41, 1'b0, 8'h55, 2, 0, 0);
    checkOutput("post_abort_full", full, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cam_fill_ctrl.md
Name: cam_fill_ctrl

Overview:
- Lookup/fill controller that initiates all traffic into the CAM cache: drives its check-tag lookup port and its active-low write port.
- Accepts tag requests from a client and queries the CAM.
- On a miss, fetches data from backing memory over a req/ack handshake, then writes the tag/data into a free or victim CAM entry.
- Returns data to the client with a hit/miss flag. Sits between client logic, one CAM instance and the memory fabric.

Parameters:
- WORDS, 8, number of CAM entries (must match the CAM instance)
- BITS, 8, data width per entry
- TAG_SZ, 8, tag width
- ADDR_LEFT, $clog2(WORDS)-1, MSB of the entry address
- CNT_W, 16, width of the statistics counters (optional feature only)

Ports:
- clk  input  1  system clock
- rst_  input  1  reset, asynchronous, active-low
- req_valid  input  1  client request valid
- req_tag  input  TAG_SZ  client tag
- req_ready  output  1  controller can accept a request
- resp_valid  output  1  response valid
- resp_data  output  BITS  response data
- resp_hit  output  1  1 = served from CAM, 0 = filled from memory
- resp_ready  input  1  client accepts the response
- cam_check_tag  output  TAG_SZ  tag to CAM lookup
- cam_found_it  input  1  CAM hit, combinational from cam_check_tag
- cam_data  input  BITS  CAM read data
- cam_write_  output  1  CAM write strobe, active-low
- cam_w_addr  output  ADDR_LEFT+1  CAM write entry
- cam_new_tag  output  TAG_SZ  tag written
- cam_wdata  output  BITS  data written
- cam_new_valid  output  1  valid bit written
- full  output  1  all WORDS entries are allocated
- mem_req  output  1  memory fetch request, level
- mem_tag  output  TAG_SZ  tag being fetched
- mem_ack  input  1  memory data valid, single-cycle pulse
- mem_rdata  input  BITS  memory data, valid with mem_ack

Behaviour:
- Reset (async):
  - state=IDLE, tag_q=0, data_q=0, alloc bitmap=0, rr_ptr=0.
  - req_ready=1; resp_valid=0, resp_data=0, resp_hit=0.
  - cam_write_=1; cam_w_addr, cam_new_tag, cam_wdata, cam_new_valid = 0.
  - mem_req=0, mem_tag=0, full=0.
- cam_check_tag = tag_q at all times (registered, glitch-free).
- IDLE:
  - req_ready=1; all other states req_ready=0.
  - On req_valid&&req_ready: tag_q<=req_tag -> LOOKUP.
- LOOKUP (exactly 1 cycle): sample cam_found_it.
  - Hit: data_q<=cam_data, resp_hit<=1 -> RESP.
  - Miss -> MREQ.
  - Hit latency: request accept to resp_valid = 2 cycles.
- MREQ:
  - mem_req=1, mem_tag=tag_q, held until mem_ack is sampled high.
  - On mem_ack: data_q<=mem_rdata, victim latched -> FILL.
  - mem_ack in any other state is ignored.
- Victim select:
  - Lowest index whose alloc bit is 0.
  - If all alloc bits are 1: rr_ptr.
- FILL (exactly 1 cycle):
  - cam_write_=0, cam_w_addr=victim, cam_new_tag=tag_q, cam_wdata=data_q, cam_new_valid=1.
  - alloc[victim]<=1.
  - If eviction (bitmap was full): rr_ptr<=rr_ptr+1, wrapping WORDS-1 -> 0 (correct for non-power-of-2 WORDS).
  - resp_hit<=0 -> RESP.
  - cam_write_ is low only in FILL.
- RESP:
  - resp_valid=1, resp_data=data_q, resp_hit stable until resp_valid&&resp_ready.
  - Then -> IDLE; req_ready rises next cycle (no back-to-back accept in the same cycle).
- full = &alloc, registered, updates the cycle after FILL.
- Mid-operation reset: abort immediately.
  - No CAM write issued.
  - mem_req drops asynchronously.
  - A late mem_ack after reset is ignored (state=IDLE).
- Tags are compared only inside the CAM. A duplicate fill cannot occur, because a miss is always checked against current CAM contents in LOOKUP.

Optional Feature:
- Macro CAM_FILL_STATS_EN.
- When defined: adds outputs hit_cnt[CNT_W-1:0], miss_cnt[CNT_W-1:0], evict_cnt[CNT_W-1:0].
  - Increment respectively on LOOKUP hit, LOOKUP miss, and FILL with eviction.
  - Saturate at all-ones; reset to 0.
  - Input stats_clr (synchronous, 1-cycle) zeroes all three; clr wins over a same-cycle increment.
- When undefined: ports, counters and logic absent; behaviour otherwise identical.

Test Plan:
- Reset: assert rst_ mid-cycle -> req_ready=1, cam_write_=1, mem_req=0, resp_valid=0, full=0 immediately.
- Cold miss: req_tag=0x5A, CAM miss, mem_ack with mem_rdata=0x33 after 3 cycles -> one-cycle cam_write_=0 with w_addr=0, new_tag=0x5A, wdata=0x33, new_valid=1; then resp_valid, resp_data=0x33, resp_hit=0.
- Hit: repeat tag 0x5A with CAM model hitting, data 0x33 -> resp_valid 2 cycles after accept, resp_hit=1, data 0x33, mem_req never asserted.
- Fill/evict: fill tags 0x01..0x08 into entries 0..7 -> full=1. Tag 0x09 writes entry 0, tag 0x0A entry 1. After 8 more evictions rr_ptr wraps to 0.
- Backpressure: mem_ack delayed 10 cycles, resp_ready low 4 cycles:
  - mem_req and mem_tag stay stable; response stays stable.
  - req_valid during busy is not accepted (req_ready=0).
- Abort: rst_ low during MREQ, then spurious mem_ack -> no CAM write, state IDLE, alloc bitmap 0. With CAM_FILL_STATS_EN, counters read 0 after reset and after stats_clr.
